// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter
// Purpose  : Round-robin front end sharing one sequential multiplier between
//            two requesters. Define MULT_ARB_TIMEOUT_EN to abort WAIT after
//            TIMEOUT_CYCLES cycles with err=1 and result=0.
// Revision : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 mult_start,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic                 mult_done,
    input  logic [2*WIDTH-1:0]   mult_product,
    output logic                 busy,
    output logic                 grant_id,
    output logic [1:0]           state_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic                 grant_q, grant_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mult_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 w_timeout;

    // Counter holds zero outside WAIT, so it is already cleared on entry.
    assign cnt_d     = (state_q == S_WAIT) ? cnt_q + c_CNT_W'(1) : '0;
    assign w_timeout = (cnt_d == c_CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
`ifdef MULT_ARB_TIMEOUT_EN
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Requester 1 wins only when requester 0 is absent or was served last.
                    grant_d = req1 && (!req0 || !last_q);
                    a_d     = grant_d ? a1 : a0;
                    b_d     = grant_d ? b1 : b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mult_done) begin
                    result_d = mult_product;
`ifdef MULT_ARB_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = S_RESP;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (w_timeout) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end
`endif
            end
            S_RESP: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign ack0       = (state_q == S_RESP) && !grant_q;
    assign ack1       = (state_q == S_RESP) &&  grant_q;
    assign result     = result_q;
    assign mult_start = (state_q == S_START);
    assign mult_a     = a_q;
    assign mult_b     = b_q;
    assign busy       = (state_q != S_IDLE);
    assign grant_id   = grant_q;
    assign state_out  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// Testbench for mult_arbiter: directed vector table, hand-written corner
// sequences and a randomised run against a transaction-level arbitration model.
module tb_mult_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req0, req1;
    logic [7:0]  a0, b0, a1, b1;
    logic        ack0, ack1, err, mult_start, mult_done, busy, grant_id;
    logic [15:0] result, mult_product;
    logic [7:0]  mult_a, mult_b;
    logic [1:0]  state_out;

    // Multiplier stand-in: automatic (done a set delay after start) or manual.
    logic        auto_en   = 1'b1;
    logic        auto_done = 1'b0;
    logic        man_done  = 1'b0;
    logic [15:0] auto_prod = '0;
    logic [15:0] man_prod  = '0;
    int          mdl_cnt   = 0;
    int          mdl_delay = 5;

    assign mult_done    = auto_en ? auto_done : man_done;
    assign mult_product = auto_en ? auto_prod : man_prod;

    mult_arbiter #(.WIDTH(8), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .result(result), .err(err),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_product(mult_product),
        .busy(busy), .grant_id(grant_id), .state_out(state_out)
    );

    always @(negedge clk) begin
        if (mdl_cnt != 0) begin
            mdl_cnt   = mdl_cnt - 1;
            auto_done = (mdl_cnt == 0);
        end else begin
            auto_done = 1'b0;
        end
        if (mult_start) begin
            mdl_cnt   = mdl_delay;
            auto_prod = {8'd0, mult_a} * {8'd0, mult_b};
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        r0, r1;
        logic [7:0]  x0, y0, x1, y1;
        int          d;
        logic        g;
        logic [15:0] res;
    } vec_t;

    vec_t tbl [8];

    int          ack_cyc, starts, nack, cyc, start_c, ack_c, d;
    logic        act, last, w, idle_now, e_ack;
    logic [7:0]  pa, pb;
    logic [15:0] p;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before test end");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'd12,  8'd11,  8'd0,   8'd0,   5, 1'b0, 16'd132};
        tbl[1] = '{1'b1, 1'b1, 8'd255, 8'd255, 8'd3,   8'd7,   5, 1'b1, 16'd21};
        tbl[2] = '{1'b1, 1'b1, 8'd255, 8'd255, 8'd3,   8'd7,   5, 1'b0, 16'hFE01};
        tbl[3] = '{1'b0, 1'b1, 8'd0,   8'd0,   8'd0,   8'd200, 3, 1'b1, 16'd0};
        tbl[4] = '{1'b0, 1'b1, 8'd0,   8'd0,   8'd255, 8'd1,   5, 1'b1, 16'd255};
        tbl[5] = '{1'b1, 1'b1, 8'd200, 8'd200, 8'd17,  8'd15,  2, 1'b0, 16'd40000};
        tbl[6] = '{1'b1, 1'b0, 8'd10,  8'd10,  8'd0,   8'd0,   1, 1'b0, 16'd100};
        tbl[7] = '{1'b1, 1'b1, 8'd1,   8'd1,   8'd128, 8'd2,   3, 1'b1, 16'd256};

        // ---- reset: req0 held during reset must not be granted
        reset = 1'b1; req0 = 1'b1; req1 = 1'b0;
        a0 = 8'd1; b0 = 8'd2; a1 = 8'd0; b1 = 8'd0;
        @(negedge clk);
        chk("reset state cycle1", state_out, 2'b00);
        @(negedge clk);
        chk("reset state", state_out, 2'b00);
        chk("reset busy", busy, 0);
        chk("reset acks", {ack0, ack1}, 0);
        chk("reset result", result, 0);
        chk("reset err", err, 0);
        chk("reset mult_start", mult_start, 0);
        chk("reset mult_a/b", {mult_a, mult_b}, 0);
        chk("reset grant_id", grant_id, 0);
        reset = 1'b0; req0 = 1'b0;
        @(negedge clk);
        chk("no grant from reset-time req", state_out, 2'b00);

        // ---- directed vector table
        for (int i = 0; i < 8; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1;
            a0 = tbl[i].x0; b0 = tbl[i].y0; a1 = tbl[i].x1; b1 = tbl[i].y1;
            mdl_delay = tbl[i].d;
            ack_cyc = -1; starts = 0;
            for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
                @(negedge clk);
                if (mult_start) begin
                    starts++;
                    chk("vec start cycle", c, 1);
                    chk("vec mult_a", mult_a, tbl[i].g ? tbl[i].x1 : tbl[i].x0);
                    chk("vec mult_b", mult_b, tbl[i].g ? tbl[i].y1 : tbl[i].y0);
                end
                if (ack0 || ack1) begin
                    ack_cyc = c;
                    chk("vec ack0", ack0, !tbl[i].g);
                    chk("vec ack1", ack1, tbl[i].g);
                    chk("vec result", result, tbl[i].res);
                    chk("vec err", err, 0);
                    chk("vec grant_id", grant_id, tbl[i].g);
                end
            end
            chk("vec ack latency", ack_cyc, tbl[i].d + 2);
            chk("vec start count", starts, 1);
            req0 = 1'b0; req1 = 1'b0;
            @(negedge clk);
            chk("vec back to idle", state_out, 2'b00);
        end

        // ---- tie held continuously: grants 0,1,0,1 every 8 cycles
        do_reset(2);
        a0 = 8'd255; b0 = 8'd255; a1 = 8'd3; b1 = 8'd7;
        mdl_delay = 5; req0 = 1'b1; req1 = 1'b1;
        nack = 0; starts = 0;
        for (int c = 1; c <= 60 && nack < 4; c++) begin
            @(negedge clk);
            if (mult_start) starts++;
            if (ack0 || ack1) begin
                chk("rr ack cycle", c, 8 * nack + 7);
                chk("rr ack0", ack0, (nack % 2) == 0);
                chk("rr ack1", ack1, (nack % 2) == 1);
                chk("rr result", result, ((nack % 2) == 0) ? 16'hFE01 : 16'd21);
                nack++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr ack count", nack, 4);
        chk("rr start count", starts, 4);

        // ---- stray done in IDLE and START; req0 dropped during WAIT
        @(negedge clk);
        auto_en = 1'b0; man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        chk("stray idle state", state_out, 2'b00);
        chk("stray idle busy", busy, 0);
        a0 = 8'd9; b0 = 8'd9; req0 = 1'b1;
        @(negedge clk);
        chk("stray start state", state_out, 2'b01);
        chk("stray start pulse", mult_start, 1);
        man_done = 1'b1; man_prod = 16'd999;
        @(negedge clk);
        chk("stray done in START ignored", state_out, 2'b10);
        chk("stray no early ack", ack0, 0);
        man_done = 1'b0; req0 = 1'b0;
        @(negedge clk);
        chk("wait holds", state_out, 2'b10);
        man_done = 1'b1; man_prod = 16'd81;
        @(negedge clk);
        chk("dropped req still acked", ack0, 1);
        chk("dropped req ack1", ack1, 0);
        chk("dropped req result", result, 16'd81);
        man_done = 1'b0;
        @(negedge clk);
        chk("stray end idle", state_out, 2'b00);

        // ---- reset in WAIT abandons the transaction
        a1 = 8'd6; b1 = 8'd7; req1 = 1'b1;
        @(negedge clk);
        chk("rst-wait start", state_out, 2'b01);
        @(negedge clk);
        chk("rst-wait in wait", state_out, 2'b10);
        reset = 1'b1;
        @(negedge clk);
        chk("rst-wait idle", state_out, 2'b00);
        chk("rst-wait no ack", {ack0, ack1}, 0);
        chk("rst-wait busy", busy, 0);
        chk("rst-wait result", result, 0);
        reset = 1'b0; auto_en = 1'b1; mdl_delay = 5;
        ack_cyc = -1;
        for (int c = 4; c <= 30 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                ack_cyc = c;
                chk("rst-wait recover ack1", ack1, 1);
                chk("rst-wait recover result", result, 16'd42);
            end
        end
        chk("rst-wait recover latency", ack_cyc, 10);
        req1 = 1'b0;
        @(negedge clk);

`ifdef MULT_ARB_TIMEOUT_EN
        // ---- timeout, then done coinciding with the timeout cycle
        auto_en = 1'b0; man_done = 1'b0;
        for (int v = 0; v < 2; v++) begin
            a0 = 8'd5; b0 = 8'd5; req0 = 1'b1; man_prod = 16'd25;
            ack_cyc = -1;
            for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
                @(negedge clk);
                if (ack0 || ack1) begin
                    ack_cyc = c;
                    chk("timeout ack0", ack0, 1);
                    chk("timeout err", err, (v == 0));
                    chk("timeout result", result, (v == 0) ? 16'd0 : 16'd25);
                end
                man_done = (v == 1) && (c == 16);
            end
            chk("timeout latency", ack_cyc, 17);
            req0 = 1'b0; man_done = 1'b0;
            @(negedge clk);
        end
        auto_en = 1'b1;
`endif

        // ---- randomised traffic against an arbitration model
        do_reset(2);
        auto_en = 1'b1; act = 1'b0; last = 1'b1; w = 1'b0; cyc = 0;
        start_c = 0; ack_c = 0; pa = '0; pb = '0; p = '0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            cyc++;
            idle_now = !act;
            e_ack = act && (cyc == ack_c);
            chk("rnd ack0", ack0, e_ack && !w);
            chk("rnd ack1", ack1, e_ack && w);
            chk("rnd mult_start", mult_start, act && (cyc == start_c));
            chk("rnd busy", busy, act && (cyc >= start_c));
            if (act && (cyc == start_c)) begin
                chk("rnd mult_a", mult_a, pa);
                chk("rnd mult_b", mult_b, pb);
            end
            if (e_ack) begin
                chk("rnd result", result, p);
                chk("rnd err", err, 0);
                last = w;
                act  = 1'b0;
            end
            if (e_ack && !w) begin
                if ($urandom_range(1) == 1) begin a0 = 8'($urandom); b0 = 8'($urandom); end
                else req0 = 1'b0;
            end else if (!req0 && $urandom_range(2) == 0) begin
                req0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom);
            end
            if (e_ack && w) begin
                if ($urandom_range(1) == 1) begin a1 = 8'($urandom); b1 = 8'($urandom); end
                else req1 = 1'b0;
            end else if (!req1 && $urandom_range(2) == 0) begin
                req1 = 1'b1; a1 = 8'($urandom); b1 = 8'($urandom);
            end
            if (idle_now && (req0 || req1)) begin
                w  = (req0 && req1) ? !last : req1;
                pa = w ? a1 : a0;
                pb = w ? b1 : b0;
                p  = {8'd0, pa} * {8'd0, pb};
                d  = $urandom_range(1, 6);
                mdl_delay = d;
                act     = 1'b1;
                start_c = cyc + 1;
                ack_c   = cyc + 2 + d;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
